// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The loader FSM states and the byte/word geometry of the host stream.
package mips_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_LOAD = 3'd2,
      ST_CHK  = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   localparam int BYTES_PER_WORD     = 4;
   localparam int DEFAULT_IMEM_DEPTH = 256;
   localparam int DEFAULT_ADDR_W     = 8;

   // States in which the host link may hand us bytes.
   function automatic logic accepts_bytes(input state_t s);
      return (s == ST_HDR) || (s == ST_LOAD) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted stream bytes into big-endian 32-bit words; word_valid fires
// combinationally with the 4th byte so the caller can register the result.
module byte_word_packer
   import mips_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  in_data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0] count_reg;
   logic [7:0] lane_reg [BYTES_PER_WORD-1];

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         count_reg <= 2'd0;
         for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
            lane_reg[i] <= 8'd0;
         end
      end else if (accept) begin
         count_reg   <= count_reg + 2'd1;
         lane_reg[0] <= in_data;
         for (int i = 1; i < BYTES_PER_WORD - 1; i++) begin
            lane_reg[i] <= lane_reg[i-1];
         end
      end
   end

   // lane 0 holds the most recent byte, so the oldest lane lands in bits 31:24.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
         assign word[8*(gi+1) +: 8] = lane_reg[gi];
      end
   endgenerate

   assign word[7:0]  = in_data;
   assign word_valid = accept && (count_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_program_loader.sv
// Boot loader: receives header/payload/checksum over a byte stream, writes the
// payload into instruction memory and releases the CPU once the XOR matches.
module imem_program_loader
   import mips_loader_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
   parameter int          ADDR_W     = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   state_t             state_reg, state_next;
   logic [ADDR_W:0]    count_n_reg, count_n_next;
   logic [31:0]        acc_reg, acc_next;
   logic [ADDR_W:0]    words_loaded_next;
   logic [ADDR_W:0]    words_loaded_inc;
   logic               imem_we_next;
   logic [ADDR_W-1:0]  imem_addr_next;
   logic [31:0]        imem_wdata_next;
   logic               in_ready_next;
   logic               cpu_reset_next;
   logic               done_next;
   logic               error_next;

   logic               packer_clear;
   logic               word_valid;
   logic [31:0]        word;

   byte_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (packer_clear),
      .accept     (in_valid && in_ready),
      .in_data    (in_data),
      .word_valid (word_valid),
      .word       (word)
   );

   assign words_loaded_inc = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         count_n_reg  <= '0;
         acc_reg      <= 32'd0;
         words_loaded <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= 32'd0;
         in_ready     <= 1'b0;
         cpu_reset    <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_n_reg  <= count_n_next;
         acc_reg      <= acc_next;
         words_loaded <= words_loaded_next;
         imem_we      <= imem_we_next;
         imem_addr    <= imem_addr_next;
         imem_wdata   <= imem_wdata_next;
         in_ready     <= in_ready_next;
         cpu_reset    <= cpu_reset_next;
         done         <= done_next;
         error        <= error_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      count_n_next      = count_n_reg;
      acc_next          = acc_reg;
      words_loaded_next = words_loaded;
      imem_we_next      = 1'b0;
      imem_addr_next    = imem_addr;
      imem_wdata_next   = imem_wdata;
      packer_clear      = 1'b0;

      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_next        = ST_HDR;
               packer_clear      = 1'b1;
               count_n_next      = '0;
               acc_next          = 32'd0;
               words_loaded_next = '0;
            end
         end
         ST_HDR: begin
            if (word_valid) begin
               if (word == 32'd0) begin
                  state_next = ST_CHK;
               end else if (word > 32'(IMEM_DEPTH)) begin
                  state_next = ST_ERR;
               end else begin
                  state_next   = ST_LOAD;
                  count_n_next = word[ADDR_W:0];
               end
            end
         end
         ST_LOAD: begin
            if (word_valid) begin
               imem_we_next      = 1'b1;
               imem_addr_next    = words_loaded[ADDR_W-1:0];
               imem_wdata_next   = word;
               acc_next          = acc_reg ^ word;
               words_loaded_next = words_loaded_inc;
               if (words_loaded_inc == count_n_reg) begin
                  state_next = ST_CHK;
               end
            end
         end
         ST_CHK: begin
            if (word_valid) begin
               state_next = (word == acc_reg) ? ST_DONE : ST_ERR;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Status flags are decoded from the next state so they are registered.
      in_ready_next  = accepts_bytes(state_next);
      cpu_reset_next = (state_next != ST_DONE);
      done_next      = (state_next == ST_DONE);
      error_next     = (state_next == ST_ERR);
   end

endmodule
